// File: rtl/bmul_arbiter.sv
// ---------------------------------------------------------------------------
// bmul_arbiter
//   Shares one bmul fixed-point multiplier between two requesters.
//   A request (two 8.8 operands) is granted round-robin, issued to bmul with
//   a one-cycle mul_in_rdy pulse, and the 16.16 result is returned with the
//   owning requester id. A watchdog aborts an operation whose result never
//   arrives and reports it through res_err. No arithmetic is done here;
//   operand and result bytes pass through bit-exact.
//
// Parameters
//   TIMEOUT   cycles allowed in WAIT before aborting (2..255)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/reqN_a/reqN_b      requester N operation (held until ack)
//   reqN_ack                      one-cycle acceptance of requester N
//   mul_{a,b}_{int,dec}           operand bytes to bmul
//   mul_in_rdy                    one-cycle start pulse to bmul
//   mul_res_{int1,int2,dec1,dec2} bmul result bytes, MSB first
//   mul_res_rdy                   bmul result valid pulse
//   res_out/res_valid/res_id      result, one-cycle strobe, owner id
//   res_err                       with res_valid: operation timed out
//   busy                          high in every state except IDLE
// ---------------------------------------------------------------------------
module bmul_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ack,
    output logic [7:0]  mul_a_int,
    output logic [7:0]  mul_a_dec,
    output logic [7:0]  mul_b_int,
    output logic [7:0]  mul_b_dec,
    output logic        mul_in_rdy,
    input  logic [7:0]  mul_res_int1,
    input  logic [7:0]  mul_res_int2,
    input  logic [7:0]  mul_res_dec1,
    input  logic [7:0]  mul_res_dec2,
    input  logic        mul_res_rdy,
    output logic [31:0] res_out,
    output logic        res_valid,
    output logic        res_id,
    output logic        res_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last counter value tolerated in WAIT; the counter starts at 0 on entry.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_ptr;       // requester preferred on the next tie
    logic [7:0]  r_cnt;
    logic        r_id;        // requester owning the operation in flight
    logic        r_ack0;
    logic        r_ack1;
    logic        r_in_rdy;
    logic [7:0]  r_a_int;
    logic [7:0]  r_a_dec;
    logic [7:0]  r_b_int;
    logic [7:0]  r_b_dec;
    logic [31:0] r_res_out;
    logic        r_res_valid;
    logic        r_res_id;
    logic        r_res_err;
    logic        r_busy;

    logic        w_any;
    logic        w_tie;
    logic        w_gid;
    logic [15:0] w_ga;
    logic [15:0] w_gb;

    // A lone requester always wins; the pointer only decides ties.
    assign w_any = req0_valid | req1_valid;
    assign w_tie = req0_valid & req1_valid;
    assign w_gid = w_tie ? r_ptr : req1_valid;
    assign w_ga  = w_gid ? req1_a : req0_a;
    assign w_gb  = w_gid ? req1_b : req0_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_cnt       <= 8'd0;
            r_id        <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_a_int     <= 8'd0;
            r_a_dec     <= 8'd0;
            r_b_int     <= 8'd0;
            r_b_dec     <= 8'd0;
            r_res_out   <= 32'd0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        // Operands are latched straight into the bmul-facing
                        // registers so they are already stable during ISSUE.
                        r_id     <= w_gid;
                        r_a_int  <= w_ga[15:8];
                        r_a_dec  <= w_ga[7:0];
                        r_b_int  <= w_gb[15:8];
                        r_b_dec  <= w_gb[7:0];
                        r_ack0   <= ~w_gid;
                        r_ack1   <= w_gid;
                        r_in_rdy <= 1'b1;
                        r_busy   <= 1'b1;
                        if (w_tie)
                            r_ptr <= ~r_ptr;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_in_rdy <= 1'b0;
                    r_cnt    <= 8'd0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the expiry cycle still wins.
                    if (mul_res_rdy) begin
                        r_res_out   <= {mul_res_int1, mul_res_int2,
                                        mul_res_dec1, mul_res_dec2};
                        r_res_err   <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_id;
                        r_state     <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res_out   <= 32'd0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_id;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    // res_out/res_id/res_err hold until the next DONE.
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ack   = r_ack0;
    assign req1_ack   = r_ack1;
    assign mul_in_rdy = r_in_rdy;
    assign mul_a_int  = r_a_int;
    assign mul_a_dec  = r_a_dec;
    assign mul_b_int  = r_b_int;
    assign mul_b_dec  = r_b_dec;
    assign res_out    = r_res_out;
    assign res_valid  = r_res_valid;
    assign res_id     = r_res_id;
    assign res_err    = r_res_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_bmul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bmul_arbiter
//   Directed self-checking bench for bmul_arbiter. Inputs are driven 1 time
//   unit after the rising edge and outputs are sampled at the same point.
//   The bmul side is played by the respond task with hand-chosen results.
// ---------------------------------------------------------------------------
module tb_bmul_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ack, req1_ack;
    logic [7:0]  mul_a_int, mul_a_dec, mul_b_int, mul_b_dec;
    logic        mul_in_rdy;
    logic [7:0]  mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2;
    logic        mul_res_rdy;
    logic [31:0] res_out;
    logic        res_valid, res_id, res_err, busy;

    int errors = 0;
    int checks = 0;

    bmul_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ack(req1_ack),
        .mul_a_int(mul_a_int), .mul_a_dec(mul_a_dec),
        .mul_b_int(mul_b_int), .mul_b_dec(mul_b_dec),
        .mul_in_rdy(mul_in_rdy),
        .mul_res_int1(mul_res_int1), .mul_res_int2(mul_res_int2),
        .mul_res_dec1(mul_res_dec1), .mul_res_dec2(mul_res_dec2),
        .mul_res_rdy(mul_res_rdy),
        .res_out(res_out), .res_valid(res_valid), .res_id(res_id),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the ISSUE cycle; raises res_rdy L cycles later for one cycle
    // and returns in the cycle after the pulse (DONE when captured).
    task automatic respond(input int L, input logic [31:0] r);
        repeat (L) tick();
        {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = r;
        mul_res_rdy = 1'b1;
        tick();
        mul_res_rdy = 1'b0;
        {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = 32'hA5A5_A5A5;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;
        mul_res_rdy = 1'b0;
        {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = 32'h0;
        repeat (3) tick();
        checks++;
        if ({req0_ack, req1_ack, mul_in_rdy, res_valid, res_id, res_err, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {req0_ack, req1_ack, mul_in_rdy, res_valid, res_id, res_err, busy});
        end
        checks++;
        if ({mul_a_int, mul_a_dec, mul_b_int, mul_b_dec} !== 32'h0) begin
            errors++;
            $display("FAIL reset_operands: got %h want 0",
                     {mul_a_int, mul_a_dec, mul_b_int, mul_b_dec});
        end
        checks++;
        if (res_out !== 32'h0) begin
            errors++; $display("FAIL reset_res_out: got %h want 0", res_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 16'h0500; req0_b = 16'h0400;
        tick();  // t+1: ISSUE
        checks++;
        if ({req1_ack, req0_ack, mul_in_rdy, busy} !== 4'b0111) begin
            errors++;
            $display("FAIL single_issue: got ack1/ack0/in_rdy/busy=%b want 0111",
                     {req1_ack, req0_ack, mul_in_rdy, busy});
        end
        checks++;
        if ({mul_a_int, mul_a_dec, mul_b_int, mul_b_dec} !== 32'h0500_0400) begin
            errors++;
            $display("FAIL single_operands: got %h want 05000400",
                     {mul_a_int, mul_a_dec, mul_b_int, mul_b_dec});
        end
        req0_valid = 1'b0; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        tick();  // t+2: WAIT
        checks++;
        if ({req0_ack, mul_in_rdy, res_valid, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL single_wait: got ack0/in_rdy/res_valid/busy=%b want 0001",
                     {req0_ack, mul_in_rdy, res_valid, busy});
        end
        checks++;
        if ({mul_a_int, mul_b_int} !== 16'h0504) begin
            errors++; $display("FAIL single_stable: got %h want 0504", {mul_a_int, mul_b_int});
        end
        tick();  // t+3
        tick();  // t+4: bmul answers (L=3)
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: got res_valid=%b want 0", res_valid);
        end
        {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = 32'h0014_0000;
        mul_res_rdy = 1'b1;
        tick();  // t+5: DONE
        mul_res_rdy = 1'b0;
        {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = 32'hA5A5_A5A5;
        checks++;
        if ({res_valid, res_id, res_err, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL single_done: got valid/id/err/busy=%b want 1001",
                     {res_valid, res_id, res_err, busy});
        end
        checks++;
        if (res_out !== 32'h0014_0000) begin
            errors++; $display("FAIL single_res_out: got %h want 00140000", res_out);
        end
        tick();  // t+6: IDLE
        checks++;
        if ({res_valid, busy} !== 2'b00 || res_out !== 32'h0014_0000) begin
            errors++;
            $display("FAIL single_after: got valid/busy=%b res_out=%h want 00 00140000",
                     {res_valid, busy}, res_out);
        end
    endtask

    task automatic test_contention();
        logic exp_id;
        req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0200;
        req1_valid = 1'b1; req1_a = 16'h0300; req1_b = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            tick();  // ISSUE
            checks++;
            if ({req1_ack, req0_ack} !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_grant%0d: got ack1/ack0=%b want id %0d",
                         i, {req1_ack, req0_ack}, exp_id);
            end
            checks++;
            if (mul_a_int !== (exp_id ? 8'h03 : 8'h01)) begin
                errors++;
                $display("FAIL contention_operand%0d: got %h want %h",
                         i, mul_a_int, exp_id ? 8'h03 : 8'h01);
            end
            respond(2, exp_id ? 32'h0003_0000 : 32'h0002_0000);
            checks++;
            if ({res_valid, res_id, res_err} !== {1'b1, exp_id, 1'b0}) begin
                errors++;
                $display("FAIL contention_done%0d: got valid/id/err=%b want 1%0d0",
                         i, {res_valid, res_id, res_err}, exp_id);
            end
            checks++;
            if (res_out !== (exp_id ? 32'h0003_0000 : 32'h0002_0000)) begin
                errors++;
                $display("FAIL contention_res%0d: got %h want %h",
                         i, res_out, exp_id ? 32'h0003_0000 : 32'h0002_0000);
            end
            if (i == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            tick();  // IDLE
        end
    endtask

    task automatic test_fractional();
        req1_valid = 1'b1; req1_a = 16'h0180; req1_b = 16'h0280;
        tick();  // ISSUE
        checks++;
        if ({req1_ack, req0_ack, mul_in_rdy} !== 3'b101) begin
            errors++;
            $display("FAIL frac_issue: got ack1/ack0/in_rdy=%b want 101",
                     {req1_ack, req0_ack, mul_in_rdy});
        end
        checks++;
        if ({mul_a_int, mul_a_dec, mul_b_int, mul_b_dec} !== 32'h0180_0280) begin
            errors++;
            $display("FAIL frac_operands: got %h want 01800280",
                     {mul_a_int, mul_a_dec, mul_b_int, mul_b_dec});
        end
        req1_valid = 1'b0;
        respond(1, 32'h0003_C000);
        checks++;
        if ({res_valid, res_id, res_err} !== 3'b110 || res_out !== 32'h0003_C000) begin
            errors++;
            $display("FAIL frac_done: got valid/id/err=%b res_out=%h want 110 0003c000",
                     {res_valid, res_id, res_err}, res_out);
        end
        tick();
    endtask

    task automatic test_timeout();
        req0_valid = 1'b1; req0_a = 16'h0A0B; req0_b = 16'h0C0D;
        tick();  // ISSUE (cycle k)
        req0_valid = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_early%0d: got res_valid=%b want 0", i, res_valid);
            end
        end
        tick();  // k+TO+1: DONE
        checks++;
        if ({res_valid, res_id, res_err, busy} !== 4'b1011) begin
            errors++;
            $display("FAIL timeout_done: got valid/id/err/busy=%b want 1011",
                     {res_valid, res_id, res_err, busy});
        end
        checks++;
        if (res_out !== 32'h0) begin
            errors++; $display("FAIL timeout_res_out: got %h want 0", res_out);
        end
        tick();  // IDLE
        checks++;
        if ({res_valid, busy, res_err} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_after: got valid/busy/err=%b want 001", {res_valid, busy, res_err});
        end
        // Late result while idle must be ignored.
        {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = 32'hCAFE_BABE;
        mul_res_rdy = 1'b1;
        tick();
        mul_res_rdy = 1'b0;
        checks++;
        if ({res_valid, busy} !== 2'b00 || res_out !== 32'h0) begin
            errors++;
            $display("FAIL timeout_late_rdy: got valid/busy=%b res_out=%h want 00 0",
                     {res_valid, busy}, res_out);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_late_rdy2: got res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_expiry_tie();
        req1_valid = 1'b1; req1_a = 16'h1122; req1_b = 16'h3344;
        tick();  // ISSUE
        req1_valid = 1'b0;
        respond(TO, 32'h1234_5678);  // lands on the last tolerated WAIT cycle
        checks++;
        if ({res_valid, res_id, res_err} !== 3'b110) begin
            errors++;
            $display("FAIL tie_done: got valid/id/err=%b want 110", {res_valid, res_id, res_err});
        end
        checks++;
        if (res_out !== 32'h1234_5678) begin
            errors++; $display("FAIL tie_res_out: got %h want 12345678", res_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_a = 16'h0200; req0_b = 16'h0300;
        req1_valid = 1'b1; req1_a = 16'h0400; req1_b = 16'h0500;
        tick();  // ISSUE: grant 0, pointer now prefers 1
        checks++;
        if ({req1_ack, req0_ack} !== 2'b01) begin
            errors++; $display("FAIL rstmid_grant: got ack1/ack0=%b want 01", {req1_ack, req0_ack});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();  // WAIT
        tick();  // WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({req0_ack, req1_ack, mul_in_rdy, res_valid, res_id, res_err, busy} !== 7'b0 ||
            {mul_a_int, mul_a_dec, mul_b_int, mul_b_dec} !== 32'h0 || res_out !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ctrl=%b ops=%h res=%h want all 0",
                     {req0_ack, req1_ack, mul_in_rdy, res_valid, res_id, res_err, busy},
                     {mul_a_int, mul_a_dec, mul_b_int, mul_b_dec}, res_out);
        end
        {mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2} = 32'h0006_0000;
        mul_res_rdy = 1'b1;
        tick();
        mul_res_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({res_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_no_result%0d: got valid/busy=%b want 00", i, {res_valid, busy});
            end
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();  // ISSUE: pointer reset, so requester 0 wins
        checks++;
        if ({req1_ack, req0_ack} !== 2'b01) begin
            errors++; $display("FAIL rstmid_regrant: got ack1/ack0=%b want 01", {req1_ack, req0_ack});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        respond(1, 32'h0006_0000);
        checks++;
        if ({res_valid, res_id, res_err} !== 3'b100 || res_out !== 32'h0006_0000) begin
            errors++;
            $display("FAIL rstmid_result: got valid/id/err=%b res_out=%h want 100 00060000",
                     {res_valid, res_id, res_err}, res_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fractional();
        test_timeout();
        test_expiry_tie();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bmul_arbiter.md
Name: bmul_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one bmul fixed-point multiplier between two requesters.
- Operands are 8.8 fixed point; the result is 16.16 fixed point.
- The block accepts a request, issues it to bmul with a one-cycle in_rdy pulse, and waits for res_rdy (bounded by a watchdog).
- It then returns the 32-bit result tagged with the requester id.
- Sits between the datapath clients and the single bmul instance.

Parameters:
- TIMEOUT, 64: maximum cycles spent in WAIT before aborting the operation with an error; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation; held until req0_ack.
- req0_a  in  16  requester 0 operand a, 8.8 ([15:8] int, [7:0] dec).
- req0_b  in  16  requester 0 operand b, 8.8.
- req0_ack  out  1  one-cycle acceptance of requester 0.
- req1_valid, req1_a, req1_b, req1_ack  same as requester 0, for requester 1.
- mul_a_int, mul_a_dec, mul_b_int, mul_b_dec  out  8 each  operands to bmul.
- mul_in_rdy  out  1  one-cycle start pulse to bmul.
- mul_res_int1, mul_res_int2, mul_res_dec1, mul_res_dec2  in  8 each  bmul result bytes, MSB first.
- mul_res_rdy  in  1  bmul result valid pulse.
- res_out  out  32  captured result {int1,int2,dec1,dec2}, 16.16.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  1  requester that owns res_out.
- res_err  out  1  with res_valid: the operation timed out; res_out = 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0 (requester 0 preferred first), timeout counter 0. A reset in any state aborts the operation silently: no res_valid, and a later bmul res_rdy is ignored.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Neither valid: stay in IDLE.
  - Exactly one valid: grant that requester.
  - Both valid: grant the requester the pointer selects; the pointer then moves to the other requester.
  - On grant: latch the operands and id, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - reqN_ack = 1 for the granted requester and mul_in_rdy = 1.
  - mul_* operands are driven from the latched registers.
  - Go to WAIT and clear the counter.
- Requester rule: deassert valid or present new operands the cycle after ack. A valid still high when the FSM returns to IDLE is a new request.
- WAIT:
  - mul_* operands stay stable; mul_in_rdy = 0; counter increments each cycle.
  - mul_res_rdy = 1: capture the four bytes into res_out, res_err = 0, go to DONE.
  - Counter reaches TIMEOUT-1 without res_rdy: res_out = 0, res_err = 1, go to DONE.
  - res_rdy on the same cycle as expiry: the result wins and res_err = 0.
- DONE (1 cycle): res_valid = 1, res_id = latched id; res_out and res_err are valid. Next state is IDLE.
- res_out, res_id and res_err hold their values until the next DONE. res_valid and res_err are meaningful only as a pair.
- mul_res_rdy outside WAIT is ignored and captures nothing.
- Latency: valid sampled in IDLE at cycle t gives ack and mul_in_rdy in cycle t+1. If bmul responds L cycles after in_rdy, res_valid occurs in cycle t+L+2.
- Minimum request-to-request spacing is 4 cycles.
- No arithmetic in this block; operand bytes are passed through bit-exact.

Test Plan:
- Single request: req0 a=16'h0500, b=16'h0400, bmul model with L=3. Expect:
  - req0_ack and mul_in_rdy at t+1 with mul_a_int=8'h05, mul_b_int=8'h04.
  - res_valid at t+5 with res_out=32'h0014_0000, res_id=0, res_err=0.
- Contention: req0 and req1 asserted together and held across 4 operations. Expect grants alternating 0,1,0,1 and res_id matching each grant.
- Fractional operands: req1 a=16'h0180 (1.5), b=16'h0280 (2.5). Expect res_out=32'h0003_C000 and res_id=1.
- Timeout: the bmul model never raises res_rdy. Expect res_valid with res_err=1 and res_out=0 exactly TIMEOUT+1 cycles after ISSUE; busy falls the following cycle. A late res_rdy in IDLE must produce no res_valid.
- Expiry tie: res_rdy arrives on the exact expiry cycle. Expect res_err=0 and the result captured.
- Reset mid-operation: assert rst for one cycle during WAIT, then deliver res_rdy. Expect no res_valid, all outputs 0, the pointer back to requester 0, and a fresh req0/req1 tie granting requester 0.
